// File: rtl/numero_seq_ctrl.sv
// numero_seq_ctrl: latches an N-digit word, steps each nibble through the numero decoder and captures its code.
// Optional LEAD_ZERO_BLANK_EN: leading zero digits (never digit 0) are sequenced but captured as 5'b00000.
module numero_seq_ctrl #(
   parameter int N_DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*N_DIGITS-1:0] digits,
   output logic                  busy,
   output logic                  done,
   output logic [5*N_DIGITS-1:0] codes,
   output logic                  dec_a,
   output logic                  dec_b,
   output logic                  dec_c,
   output logic                  dec_d,
   output logic                  dec_ready,
   output logic                  dec_reset,
   input  logic                  dec_v,
   input  logic                  dec_w,
   input  logic                  dec_x,
   input  logic                  dec_y,
   input  logic                  dec_z
);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DRIVE, S_CAPTURE, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [N_DIGITS-1:0][3:0] digits_arr;
   logic [N_DIGITS-1:0][3:0] word_q, word_d;
   logic [N_DIGITS-1:0][4:0] codes_q, codes_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [3:0]               nib_q, nib_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     ready_q, ready_d;
   logic                     dec_reset_q;
   logic [4:0]               dec_code;
   logic [4:0]               cap_code;

   assign digits_arr = digits;
   assign dec_code   = {dec_v, dec_w, dec_x, dec_y, dec_z};

`ifdef LEAD_ZERO_BLANK_EN
   logic [N_DIGITS-1:0] blank_q, blank_d, blank_mask;
   logic                any_nz;

   // Scan from the top digit down: a digit is blank while nothing at or above it is non-zero.
   // NOTE: blocking assignments here build a combinational OR chain; any_nz is a temporary, not state.
   always_comb begin
      any_nz     = 1'b0;
      blank_mask = '0;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         any_nz        = any_nz | (|digits_arr[k]);
         blank_mask[k] = (k != 0) && !any_nz;
      end
   end

   always_comb begin
      blank_d = blank_q;
      if ((state_q == S_IDLE) && start) blank_d = blank_mask;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) blank_q <= '0;
      else       blank_q <= blank_d;
   end

   assign cap_code = blank_q[idx_q] ? 5'b00000 : dec_code;
`else
   assign cap_code = dec_code;
`endif

   // Outputs are registered, so each one is loaded on the transition INTO the state that shows it.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      codes_d = codes_q;
      nib_d   = nib_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ready_d = ready_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               word_d  = digits_arr;
               idx_d   = '0;
               busy_d  = 1'b1;
               ready_d = 1'b1;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            nib_d   = word_q[idx_q];
            state_d = S_DRIVE;
         end
         S_DRIVE: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            codes_d[idx_q] = cap_code;
            if (idx_q == LAST_IDX) begin
               done_d  = 1'b1;
               ready_d = 1'b0;
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               nib_d   = word_q[idx_d];
               state_d = S_DRIVE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: every flop, including the code store, is cleared by reset so a mid-run reset leaves codes at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         word_q      <= '0;
         idx_q       <= '0;
         codes_q     <= '0;
         nib_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b0;
         dec_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         idx_q       <= idx_d;
         codes_q     <= codes_d;
         nib_q       <= nib_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
         dec_reset_q <= 1'b0;
      end
   end

   assign busy                         = busy_q;
   assign done                         = done_q;
   assign codes                        = codes_q;
   assign {dec_a, dec_b, dec_c, dec_d} = nib_q;
   assign dec_ready                    = ready_q;
   assign dec_reset                    = dec_reset_q;

endmodule
